multicycle_control: RTL

Sequencing controller for the multicycle RV32I core variant. Drives the shared datapath (single memory port, single ALU, register file, instruction register, and the immediate generator that decodes the instruction register's opcode) through fetch, decode, execute, memory and writeback steps. Handles a ready-based memory handshake and traps on unsupported opcodes. The controller is a Moore FSM; a small set of strobes is qualified by datapath or memory inputs.

---
 rtl/multicycle_control.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Sequencing controller for the multicycle RV32I core. Steps the
//            shared datapath (one memory port, one ALU, register file,
//            instruction register, immediate generator) through fetch,
//            decode, execute, memory and writeback. Uses a ready-based memory
//            handshake and traps on unsupported opcodes or branch funct3.
//            Moore FSM; a few strobes are qualified by mem_ready, zero and
//            funct3.
// Ports    :
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous active-high reset
//   opcode      in   7  instruction register [6:0]
//   funct3      in   3  instruction register [14:12]
//   zero        in   1  ALU zero flag (combinational)
//   mem_ready   in   1  memory completes current request this cycle
//   mem_req     out  1  memory request, held until mem_ready
//   mem_we      out  1  write request (valid with mem_req)
//   addr_src    out  1  memory address select: 0=PC, 1=alu_out
//   ir_write    out  1  load IR and old_pc
//   pc_write    out  1  load PC from result mux
//   reg_write   out  1  register file write
//   alu_src_a   out  2  00=PC, 01=old_pc, 10=rs1
//   alu_src_b   out  2  00=rs2, 01=ImmExt, 10=const 4
//   alu_op      out  2  00=add, 01=sub, 10=funct decode
//   result_src  out  2  00=alu_out, 01=mem data reg, 10=ALU direct
//   instr_done  out  1  pulse on last cycle of each completed instruction
//   illegal     out  1  high while trapped
//   state       out  4  current state encoding (debug)
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd10
    } state_t;

    // Opcodes the controller understands
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

    // Mux / ALU field encodings
    localparam logic [1:0] c_a_pc     = 2'b00;
    localparam logic [1:0] c_a_old_pc = 2'b01;
    localparam logic [1:0] c_a_rs1    = 2'b10;

    localparam logic [1:0] c_b_rs2    = 2'b00;
    localparam logic [1:0] c_b_imm    = 2'b01;
    localparam logic [1:0] c_b_four   = 2'b10;

    localparam logic [1:0] c_alu_add  = 2'b00;
    localparam logic [1:0] c_alu_sub  = 2'b01;
    localparam logic [1:0] c_alu_func = 2'b10;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_mdr    = 2'b01;
    localparam logic [1:0] c_res_alu    = 2'b10;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = c_a_pc;
        alu_src_b  = c_b_rs2;
        alu_op     = c_alu_add;
        result_src = c_res_aluout;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed by the ALU and written straight back
                // to PC on the same cycle the instruction word arrives.
                mem_req    = 1'b1;
                addr_src   = 1'b0;
                alu_src_a  = c_a_pc;
                alu_src_b  = c_b_four;
                alu_op     = c_alu_add;
                result_src = c_res_alu;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculatively compute old_pc + imm as the branch target;
                // it lands in alu_out for use by BRANCH.
                alu_src_a = c_a_old_pc;
                alu_src_b = c_b_imm;
                alu_op    = c_alu_add;
                case (opcode)
                    c_op_load,
                    c_op_store:  state_d = S_MEM_ADDR;
                    c_op_rtype:  state_d = S_EXEC_R;
                    c_op_itype:  state_d = S_EXEC_I;
                    c_op_branch: state_d = S_BRANCH;
                    default:     state_d = S_TRAP;
                endcase
            end

            S_MEM_ADDR: begin
                alu_src_a = c_a_rs1;
                alu_src_b = c_b_imm;
                alu_op    = c_alu_add;
                if (opcode == c_op_load) begin
                    state_d = S_MEM_READ;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end

            S_MEM_READ: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                result_src = c_res_mdr;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_EXEC_R: begin
                alu_src_a = c_a_rs1;
                alu_src_b = c_b_rs2;
                alu_op    = c_alu_func;
                state_d   = S_ALU_WB;
            end

            S_EXEC_I: begin
                alu_src_a = c_a_rs1;
                alu_src_b = c_b_imm;
                alu_op    = c_alu_func;
                state_d   = S_ALU_WB;
            end

            S_ALU_WB: begin
                result_src = c_res_aluout;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                // Compare rs1 - rs2; the target computed in DECODE is
                // sitting in alu_out and is selected onto the result bus.
                alu_src_a  = c_a_rs1;
                alu_src_b  = c_b_rs2;
                alu_op     = c_alu_sub;
                result_src = c_res_aluout;
                case (funct3)
                    c_f3_beq: begin
                        pc_write   = zero;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    c_f3_bne: begin
                        pc_write   = ~zero;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: begin
                        state_d = S_TRAP;
                    end
                endcase
            end

            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end

            default: begin
                // Unreachable encodings recover through FETCH.
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every output regardless of the current state.
        if (rst) begin
            state_d    = S_FETCH;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_src   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = c_a_pc;
            alu_src_b  = c_b_rs2;
            alu_op     = c_alu_add;
            result_src = c_res_aluout;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire
